// File: rtl/step_dir_decoder.sv
// -----------------------------------------------------------------------------
// step_dir_decoder
//
// Receives an external step/dir command stream, synchronizes and edge-detects
// the step pin, tracks a wrapping position counter, measures the step period
// and flags direction-setup violations.
//
// Optional feature macro: STEP_DIR_DECODER_FILTER_EN
//   defined   -> synchronized step passes through a FILT_LEN-cycle glitch filter
//   undefined -> synchronized step feeds the edge detector directly
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   step_in       in   asynchronous step pin
//   dir_in        in   asynchronous direction pin (1 = count up)
//   en            in   position count enable
//   clr           in   synchronous clear of pos and dir_err
//   pos           out  POS_W position, two's complement, wraps
//   step_pulse    out  one-cycle strobe per accepted step rising edge
//   dir_out       out  synchronized direction
//   period        out  PER_W cycles between the last two accepted edges
//   period_valid  out  period holds a real measurement
//   dir_err       out  sticky direction-setup violation
// -----------------------------------------------------------------------------
module step_dir_decoder #(
    parameter int POS_W     = 16,
    parameter int PER_W     = 16,
    parameter int FILT_LEN  = 4,
    parameter int DIR_SETUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             en,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             step_pulse,
    output logic             dir_out,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             dir_err
);

    localparam int               AGE_W   = $clog2(DIR_SETUP + 1);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(DIR_SETUP);
    localparam logic [PER_W-1:0] PER_MAX = '1;

    if (FILT_LEN < 1 || DIR_SETUP < 1) begin : g_param_check
        $error("step_dir_decoder: FILT_LEN and DIR_SETUP must be >= 1");
    end

    logic             step_s1_q, step_s2_q, dir_s1_q, dir_s2_q;
    logic             step_cond;
    logic             step_prev_q;
    logic             step_edge;
    logic             step_pulse_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [AGE_W-1:0] dir_age_q, dir_age_d;
    logic             dir_err_q, dir_err_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             seen_q, seen_d;

`ifdef STEP_DIR_DECODER_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic            filt_q, filt_d;
    logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;

    // Output follows s2 only after FILT_LEN consecutive cycles of disagreement.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (step_s2_q != filt_q) begin
            if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
                filt_d = step_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign step_cond = filt_q;
`else
    assign step_cond = step_s2_q;
`endif

    assign step_edge = step_cond & ~step_prev_q;

    always_comb begin
        pos_d = pos_q;
        if (clr) begin
            pos_d = '0;
        end else if (step_edge && en) begin
            pos_d = dir_s2_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end

        // Age restarts at the edge where dir_out is about to change.
        dir_age_d = dir_age_q;
        if (dir_s1_q != dir_s2_q) begin
            dir_age_d = '0;
        end else if (dir_age_q != AGE_SAT) begin
            dir_age_d = dir_age_q + AGE_W'(1);
        end

        dir_err_d = dir_err_q;
        if (clr) begin
            dir_err_d = 1'b0;
        end else if (step_edge && (dir_age_q < AGE_SAT)) begin
            dir_err_d = 1'b1;
        end

        // seen_q: one edge already observed since reset or the last stall,
        // so the next edge yields a real measurement.
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        seen_d         = seen_q;
        if (step_edge) begin
            period_d       = (cnt_q == PER_MAX) ? PER_MAX : cnt_q + PER_W'(1);
            period_valid_d = seen_q && (cnt_q != PER_MAX);
            seen_d         = 1'b1;
            cnt_d          = '0;
        end else if (cnt_q == PER_MAX) begin
            period_d       = PER_MAX;
            period_valid_d = 1'b0;
            seen_d         = 1'b0;
        end else begin
            cnt_d = cnt_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_s1_q      <= 1'b0;
            step_s2_q      <= 1'b0;
            dir_s1_q       <= 1'b0;
            dir_s2_q       <= 1'b0;
            step_prev_q    <= 1'b0;
            step_pulse_q   <= 1'b0;
            pos_q          <= '0;
            dir_age_q      <= '0;
            dir_err_q      <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            seen_q         <= 1'b0;
        end else begin
            step_s1_q      <= step_in;
            step_s2_q      <= step_s1_q;
            dir_s1_q       <= dir_in;
            dir_s2_q       <= dir_s1_q;
            step_prev_q    <= step_cond;
            step_pulse_q   <= step_edge;
            pos_q          <= pos_d;
            dir_age_q      <= dir_age_d;
            dir_err_q      <= dir_err_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            seen_q         <= seen_d;
        end
    end

    assign pos          = pos_q;
    assign step_pulse   = step_pulse_q;
    assign dir_out      = dir_s2_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign dir_err      = dir_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// -----------------------------------------------------------------------------
// tb_step_dir_decoder
//
// Directed bench for step_dir_decoder with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_step_dir_decoder;

    localparam int POS_W = 16;
    localparam int PER_W = 16;
`ifdef STEP_DIR_DECODER_FILTER_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst, step_in, dir_in, en, clr;
    logic [POS_W-1:0] pos;
    logic             step_pulse, dir_out, period_valid, dir_err;
    logic [PER_W-1:0] period;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    step_dir_decoder #(
        .POS_W(POS_W), .PER_W(PER_W), .FILT_LEN(4), .DIR_SETUP(2)
    ) dut (
        .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in),
        .en(en), .clr(clr), .pos(pos), .step_pulse(step_pulse),
        .dir_out(dir_out), .period(period), .period_valid(period_valid),
        .dir_err(dir_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (step_pulse) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        step_in = 1'b1;
        cycles(hi);
        step_in = 1'b0;
        cycles(lo);
    endtask

    initial begin
        rst = 1'b1; step_in = 1'b0; dir_in = 1'b0; en = 1'b0; clr = 1'b0;
        cycles(3);
        check("rst_pos",    32'(pos), 32'h0);
        check("rst_pulse",  32'(step_pulse), 32'h0);
        check("rst_dir",    32'(dir_out), 32'h0);
        check("rst_period", 32'(period), 32'h0);
        check("rst_valid",  32'(period_valid), 32'h0);
        check("rst_err",    32'(dir_err), 32'h0);
        rst = 1'b0;

        // five 4/4 steps counting up
        dir_in = 1'b1; en = 1'b1;
        cycles(6);
        check("dir_sync", 32'(dir_out), 32'h1);
        pulse_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(4, 4);
            if (i == 0) check("valid_after_1st", 32'(period_valid), 32'h0);
            if (i == 1) begin
                check("valid_after_2nd", 32'(period_valid), 32'h1);
                check("period_after_2nd", 32'(period), 32'd8);
            end
        end
        cycles(LAT + 2);
        check("up5_pos",    32'(pos), 32'd5);
        check("up5_pulses", 32'(pulse_cnt), 32'd5);
        check("up5_period", 32'(period), 32'd8);
        check("up5_valid",  32'(period_valid), 32'h1);
        check("up5_err",    32'(dir_err), 32'h0);

        // wrap down then back up
        clr = 1'b1; cycles(1); clr = 1'b0;
        check("clr_pos", 32'(pos), 32'h0);
        dir_in = 1'b0; cycles(6);
        pulse(4, 4); cycles(LAT);
        check("wrap_down", 32'(pos), 32'hFFFF);
        dir_in = 1'b1; cycles(6);
        pulse(4, 4); pulse(4, 4); cycles(LAT);
        check("wrap_up", 32'(pos), 32'd1);
        check("wrap_err", 32'(dir_err), 32'h0);

        // en = 0: position holds, strobes continue
        en = 1'b0; pulse_cnt = 0;
        repeat (3) pulse(4, 4);
        cycles(LAT);
        check("hold_pos",    32'(pos), 32'd1);
        check("hold_pulses", 32'(pulse_cnt), 32'd3);
        en = 1'b1;

        // clr coincides with the edge that would count the step
        step_in = 1'b1;
        cycles(LAT);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("clr_step_pulse", 32'(step_pulse), 32'h1);
        check("clr_step_pos",   32'(pos), 32'h0);
        cycles(3);
        step_in = 1'b0;
        cycles(4 + LAT);
        check("clr_step_after", 32'(pos), 32'h0);

        // dir changes one cycle before step rises: violation, step still counted
        dir_in = 1'b0;
        cycles(1);
        pulse(4, 4); cycles(LAT);
        check("setup_err", 32'(dir_err), 32'h1);
        check("setup_pos", 32'(pos), 32'hFFFF);
        clr = 1'b1; cycles(1); clr = 1'b0;
        check("setup_clr_err", 32'(dir_err), 32'h0);
        check("setup_clr_pos", 32'(pos), 32'h0);

        // stall then recovery
        cycles(65540);
        check("stall_period", 32'(period), 32'hFFFF);
        check("stall_valid",  32'(period_valid), 32'h0);
        pulse(4, 6);
        check("stall_1st_valid",  32'(period_valid), 32'h0);
        check("stall_1st_period", 32'(period), 32'hFFFF);
        pulse(4, 6);
        check("recover_period", 32'(period), 32'd10);
        check("recover_valid",  32'(period_valid), 32'h1);
        cycles(LAT);
        check("recover_pos", 32'(pos), 32'hFFFE);

        // two-cycle glitch
        pulse_cnt = 0;
        pulse(2, 8);
        cycles(LAT);
`ifdef STEP_DIR_DECODER_FILTER_EN
        check("glitch_pos",    32'(pos), 32'hFFFE);
        check("glitch_pulses", 32'(pulse_cnt), 32'd0);
`else
        check("glitch_pos",    32'(pos), 32'hFFFD);
        check("glitch_pulses", 32'(pulse_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receives an external step/dir command stream, synchronizes and edge-detects it, and tracks a position counter.
- Sits on the input side of the stepper fabric, as the counterpart of the step/dir generator: it consumes what a generator drives onto the pins.
- Also reports step period and direction-setup violations, for diagnostics and closed-loop comparison.

## Interface
Parameters:
- POS_W, 16, width of the position counter (two's complement, wraps)
- PER_W, 16, width of the period counter (saturating)
- FILT_LEN, 4, consecutive stable cycles required by the step glitch filter (when compiled in)
- DIR_SETUP, 2, minimum cycles dir must be stable before a step rising edge

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- step_in  in  1  asynchronous step pin
- dir_in  in  1  asynchronous direction pin; 1 = count up
- en  in  1  position count enable
- clr  in  1  synchronous clear of position and dir_err
- pos  out  POS_W  current position
- step_pulse  out  1  one-cycle strobe per accepted step rising edge
- dir_out  out  1  synchronized direction
- period  out  PER_W  cycles between the last two accepted edges
- period_valid  out  1  period holds a real measurement
- dir_err  out  1  sticky direction-setup violation flag

## Operation
Reset values (rst high at a clk edge): all outputs 0; synchronizers, filter, age and period counters 0.

Input path:
- step_in and dir_in each pass through a 2-flop synchronizer (s1, s2). dir_out is the s2 output of dir_in.
- A step rising edge is detected when the conditioned step (s2, or the filter output) is 1 and its registered previous value is 0. step_pulse is registered; it is high for exactly one cycle per detected edge.

Position (updated at the same edge that sets step_pulse):
- clr = 1: pos = 0. clr wins over a simultaneous step.
- Else, edge detected and en = 1: pos = pos + 1 if dir_out = 1, otherwise pos - 1. Modulo 2^POS_W: 0 - 1 = all ones, all ones + 1 = 0.
- en = 0: pos holds. step_pulse, period and dir_err still operate.

Direction setup check:
- dir_age counter resets to 0 on any change of dir_out, then increments each cycle, saturating at DIR_SETUP.
- Edge detected with dir_age < DIR_SETUP: dir_err is set. The step is still counted, using the current dir_out.
- dir_err is cleared only by clr or rst. clr and a violation in the same cycle: dir_err = 0.

Period measurement:
- Counter cnt increments each cycle and saturates at 2^PER_W - 1.
- On an edge: period = min(cnt + 1, 2^PER_W - 1) and cnt = 0. For steps every N cycles, period = N.
- period_valid goes to 1 on the second and later edges after reset or a stall.
- Stall: cnt reaches saturation. Then period = all ones and period_valid = 0, until two further edges occur.
- clr does not affect period logic.

## Timing
- Filter absent: step_in sampled high at edge k (previously low) gives step_pulse high in the cycle after edge k+2. pos, period and dir_err update at edge k+2.
- Filter present: same path plus FILT_LEN cycles, i.e. update at edge k+2+FILT_LEN.
- dir_in uses the same 2-cycle synchronizer latency. A dir change and a step edge reaching s2 in the same cycle is a violation, because dir_age = 0.
- Maximum accepted step rate: one edge per 2 cycles without filter, per 2·FILT_LEN cycles with filter.
- rst mid-operation: all state returns to reset values at that edge. An in-flight edge is discarded.

## Configuration
- STEP_DIR_DECODER_FILTER_EN defined: the step path (after the synchronizer) goes through a glitch filter.
  - The filter output changes only after s2 has differed from it for FILT_LEN consecutive cycles.
  - Shorter pulses are ignored entirely.
- Undefined: s2 feeds edge detection directly. FILT_LEN is unused, and every synchronized pulse of 1 cycle or longer counts.

## Test plan
- rst, then dir_in = 1, en = 1, 5 step pulses of 4 high / 4 low cycles -> pos = 5, five single-cycle step_pulse strobes, period = 8 with period_valid = 1 after the 2nd edge.
- From pos = 0, dir_in = 0, one step -> pos = 16'hFFFF. Then dir_in = 1, two steps -> pos = 1.
- en = 0 with 3 steps -> pos unchanged, 3 step_pulse strobes. clr asserted in the same cycle as a step_pulse -> pos = 0 the next cycle.
- dir_in toggled 1 cycle before step_in rises -> dir_err = 1 and the step is still counted. Then clr -> dir_err = 0.
- No steps for 2^16 cycles after valid stepping -> period = 16'hFFFF, period_valid = 0. Two steps 10 cycles apart -> period = 10, period_valid = 1.
- 2-cycle-wide step glitch: with STEP_DIR_DECODER_FILTER_EN and FILT_LEN = 4 -> no step_pulse, pos unchanged. Without the macro -> pos changes by 1.
